// File: rtl/ct_cp0_rst_pkg.sv
// Shared state encodings and default widths for the CP0 reset-invalidate slice.
// Optional macro CT_CP0_RST_BHT_INV_EN adds the one-hot BHTINV state bit.
package ct_cp0_rst_pkg;

   localparam int RST_INDEX_WIDTH = 8;
   localparam int RST_PC_WIDTH    = 40;

`ifdef CT_CP0_RST_BHT_INV_EN
   localparam int RST_STATE_WIDTH = 4;
`else
   localparam int RST_STATE_WIDTH = 3;
`endif

   localparam logic [RST_STATE_WIDTH-1:0] RST_IDLE  = RST_STATE_WIDTH'(3'b001);
   localparam logic [RST_STATE_WIDTH-1:0] RST_ICINV = RST_STATE_WIDTH'(3'b010);
   localparam logic [RST_STATE_WIDTH-1:0] RST_DONE  = RST_STATE_WIDTH'(3'b100);
`ifdef CT_CP0_RST_BHT_INV_EN
   localparam logic [RST_STATE_WIDTH-1:0] RST_BHTINV = RST_STATE_WIDTH'(4'b1000);
`endif

   typedef enum logic [RST_STATE_WIDTH-1:0] {
      ST_IDLE   = RST_IDLE,
      ST_ICINV  = RST_ICINV,
`ifdef CT_CP0_RST_BHT_INV_EN
      ST_BHTINV = RST_BHTINV,
`endif
      ST_DONE   = RST_DONE
   } rst_state_e;

   // Walk states that keep the vector state-machine clock running.
   function automatic logic rst_state_busy(input rst_state_e s);
`ifdef CT_CP0_RST_BHT_INV_EN
      return (s == ST_ICINV) || (s == ST_BHTINV);
`else
      return (s == ST_ICINV);
`endif
   endfunction

endpackage

// File: rtl/ct_cp0_rst_idx_cnt.sv
// I-cache set-index counter for the reset walk: clear-to-zero, grant increment,
// and an all-ones terminal flag so the counter never wraps.
module ct_cp0_rst_idx_cnt
   import ct_cp0_rst_pkg::*;
#(
   parameter int INDEX_WIDTH = RST_INDEX_WIDTH
) (
   input  logic                   vec_sm_clk,
   input  logic                   cpurst_b,
   input  logic                   cnt_clr,
   input  logic                   cnt_inc,
   output logic [INDEX_WIDTH-1:0] cnt_index,
   output logic                   cnt_last
);

   logic [INDEX_WIDTH-1:0] index_reg;

   always_ff @(posedge vec_sm_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         index_reg <= '0;
      end else if (cnt_clr) begin
         index_reg <= '0;
      end else if (cnt_inc && !cnt_last) begin
         index_reg <= index_reg + INDEX_WIDTH'(1);
      end
   end

   assign cnt_index = index_reg;
   assign cnt_last  = &index_reg;

endmodule

// File: rtl/ct_cp0_rst_inv_ctrl.sv
// CP0 responder to the IFU vector reset handshake: walks every I-cache index,
// then signals done; captures the reset vector base. Optional macro: CT_CP0_RST_BHT_INV_EN.
module ct_cp0_rst_inv_ctrl
   import ct_cp0_rst_pkg::*;
#(
   parameter int INDEX_WIDTH = RST_INDEX_WIDTH,
   parameter int PC_WIDTH    = RST_PC_WIDTH
) (
   input  logic                   vec_sm_clk,
   input  logic                   cpurst_b,
   input  logic                   ifu_cp0_rst_inv_req,
   input  logic                   ifu_cp0_rst_mrvbr_req,
   input  logic [PC_WIDTH-1:0]    pad_cpu_rvba,
   input  logic                   icache_cp0_inv_grant,
`ifdef CT_CP0_RST_BHT_INV_EN
   input  logic                   bht_cp0_inv_done,
   output logic                   cp0_bht_inv_req,
`endif
   output logic                   cp0_ifu_rst_inv_done,
   output logic [PC_WIDTH-1:0]    cp0_ifu_rvbr,
   output logic                   cp0_icache_inv_req,
   output logic [INDEX_WIDTH-1:0] cp0_icache_inv_index,
   output logic                   cp0_rst_inv_busy
);

   rst_state_e             state_reg;
   rst_state_e             state_next;
   logic                   idx_clr;
   logic                   idx_inc;
   logic                   idx_last;
   logic [INDEX_WIDTH-1:0] idx_value;
   logic [PC_WIDTH-1:0]    rvbr_reg;

   ct_cp0_rst_idx_cnt #(
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_idx_cnt (
      .vec_sm_clk (vec_sm_clk),
      .cpurst_b   (cpurst_b),
      .cnt_clr    (idx_clr),
      .cnt_inc    (idx_inc),
      .cnt_index  (idx_value),
      .cnt_last   (idx_last)
   );

   always_ff @(posedge vec_sm_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A new request is only honoured from IDLE or DONE; mid-walk requests are dropped.
   always_comb begin
      state_next = state_reg;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (ifu_cp0_rst_inv_req) begin
               state_next = ST_ICINV;
               idx_clr    = 1'b1;
            end
         end
         ST_ICINV: begin
            if (icache_cp0_inv_grant) begin
               if (idx_last) begin
`ifdef CT_CP0_RST_BHT_INV_EN
                  state_next = ST_BHTINV;
`else
                  state_next = ST_DONE;
`endif
               end else begin
                  idx_inc = 1'b1;
               end
            end
         end
`ifdef CT_CP0_RST_BHT_INV_EN
         ST_BHTINV: begin
            if (bht_cp0_inv_done) begin
               state_next = ST_DONE;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The reload is independent of the walk; a micro-reset without mrvbr keeps rvbr.
   always_ff @(posedge vec_sm_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rvbr_reg <= '0;
      end else if (ifu_cp0_rst_mrvbr_req) begin
         rvbr_reg <= {pad_cpu_rvba[PC_WIDTH-1:1], 1'b0};
      end
   end

   assign cp0_ifu_rst_inv_done = (state_reg == ST_DONE);
   assign cp0_ifu_rvbr         = rvbr_reg;
   assign cp0_icache_inv_req   = (state_reg == ST_ICINV);
   assign cp0_icache_inv_index = idx_value;
   assign cp0_rst_inv_busy     = rst_state_busy(state_reg);
`ifdef CT_CP0_RST_BHT_INV_EN
   assign cp0_bht_inv_req      = (state_reg == ST_BHTINV);
`endif

endmodule

// File: tb/tb_ct_cp0_rst_inv_ctrl.sv
// Directed bench for ct_cp0_rst_inv_ctrl: expected indices are queued at request time
// and popped as the I-cache grants them. Honours CT_CP0_RST_BHT_INV_EN when defined.
module tb_ct_cp0_rst_inv_ctrl;

   localparam int IW = 8;
   localparam int PW = 40;
`ifdef CT_CP0_RST_BHT_INV_EN
   localparam int BHT_EXTRA = 5;
`else
   localparam int BHT_EXTRA = 0;
`endif

   logic          vec_sm_clk;
   logic          cpurst_b;
   logic          ifu_cp0_rst_inv_req;
   logic          ifu_cp0_rst_mrvbr_req;
   logic [PW-1:0] pad_cpu_rvba;
   logic          icache_cp0_inv_grant;
   logic          cp0_ifu_rst_inv_done;
   logic [PW-1:0] cp0_ifu_rvbr;
   logic          cp0_icache_inv_req;
   logic [IW-1:0] cp0_icache_inv_index;
   logic          cp0_rst_inv_busy;
`ifdef CT_CP0_RST_BHT_INV_EN
   logic          bht_cp0_inv_done;
   logic          cp0_bht_inv_req;
`endif

   int checks   = 0;
   int failures = 0;
   logic [IW-1:0] exp_q[$];

   ct_cp0_rst_inv_ctrl #(
      .INDEX_WIDTH (IW),
      .PC_WIDTH    (PW)
   ) dut (
      .vec_sm_clk            (vec_sm_clk),
      .cpurst_b              (cpurst_b),
      .ifu_cp0_rst_inv_req   (ifu_cp0_rst_inv_req),
      .ifu_cp0_rst_mrvbr_req (ifu_cp0_rst_mrvbr_req),
      .pad_cpu_rvba          (pad_cpu_rvba),
      .icache_cp0_inv_grant  (icache_cp0_inv_grant),
`ifdef CT_CP0_RST_BHT_INV_EN
      .bht_cp0_inv_done      (bht_cp0_inv_done),
      .cp0_bht_inv_req       (cp0_bht_inv_req),
`endif
      .cp0_ifu_rst_inv_done  (cp0_ifu_rst_inv_done),
      .cp0_ifu_rvbr          (cp0_ifu_rvbr),
      .cp0_icache_inv_req    (cp0_icache_inv_req),
      .cp0_icache_inv_index  (cp0_icache_inv_index),
      .cp0_rst_inv_busy      (cp0_rst_inv_busy)
   );

   initial vec_sm_clk = 1'b0;
   always #5 vec_sm_clk = ~vec_sm_clk;

   task automatic tick();
      @(posedge vec_sm_clk);
      @(negedge vec_sm_clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic [PW-1:0] exp_rvbr);
      check({tag, "_done"},  64'(cp0_ifu_rst_inv_done), 64'd0);
      check({tag, "_invreq"}, 64'(cp0_icache_inv_req), 64'd0);
      check({tag, "_busy"},  64'(cp0_rst_inv_busy), 64'd0);
      check({tag, "_rvbr"},  64'(cp0_ifu_rvbr), 64'(exp_rvbr));
`ifdef CT_CP0_RST_BHT_INV_EN
      check({tag, "_bhtreq"}, 64'(cp0_bht_inv_req), 64'd0);
`endif
   endtask

   // Issue the request pulse and queue the full index sequence the walk must produce.
   task automatic start(input logic mrvbr);
      exp_q.delete();
      for (int i = 0; i < (1 << IW); i++) exp_q.push_back(IW'(i));
      ifu_cp0_rst_inv_req   = 1'b1;
      ifu_cp0_rst_mrvbr_req = mrvbr;
      icache_cp0_inv_grant  = 1'b1;
      tick();
      ifu_cp0_rst_inv_req   = 1'b0;
      ifu_cp0_rst_mrvbr_req = 1'b0;
   endtask

   // Runs from cycle 1 after the request edge until done, comparing every issued index.
   task automatic walk(input string tag, input bit toggle, input int pulse_idx,
                       input int abort_idx, input int exp_done);
      int cyc        = 1;
      int done_cyc   = -1;
      int last_grant = -1;
      int bht_cycles = 0;
      bit pulsed     = 1'b0;
      while (cyc < 2000) begin
         if (cp0_ifu_rst_inv_done) begin
            done_cyc = cyc;
            break;
         end
         icache_cp0_inv_grant = toggle ? cyc[0] : 1'b1;
         ifu_cp0_rst_inv_req  = 1'b0;
         if (!pulsed && cp0_icache_inv_req && int'(cp0_icache_inv_index) == pulse_idx) begin
            ifu_cp0_rst_inv_req = 1'b1;
            pulsed = 1'b1;
         end
         if (cp0_icache_inv_req && int'(cp0_icache_inv_index) == abort_idx) begin
            cpurst_b = 1'b0;
            #1;
            check_idle({tag, "_abort"}, '0);
            check({tag, "_abort_idx"}, 64'(cp0_icache_inv_index), 64'd0);
            exp_q.delete();
            return;
         end
`ifdef CT_CP0_RST_BHT_INV_EN
         bht_cp0_inv_done = (cyc == 10) || (last_grant >= 0 && cyc == last_grant + 5);
         if (cp0_bht_inv_req) bht_cycles++;
`endif
         if (cp0_icache_inv_req) begin
            if (exp_q.size() == 0) begin
               check({tag, "_extra_idx"}, 64'(cp0_icache_inv_req), 64'd0);
            end else begin
               check({tag, "_idx"}, 64'(cp0_icache_inv_index), 64'(exp_q[0]));
               check({tag, "_busy"}, 64'(cp0_rst_inv_busy), 64'd1);
               if (icache_cp0_inv_grant) begin
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) last_grant = cyc;
               end
            end
         end
         tick();
         cyc++;
      end
      ifu_cp0_rst_inv_req = 1'b0;
`ifdef CT_CP0_RST_BHT_INV_EN
      bht_cp0_inv_done = 1'b0;
      check({tag, "_bht_cycles"}, 64'(bht_cycles), 64'(BHT_EXTRA));
`endif
      check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
      check({tag, "_q_drained"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_busy_done"}, 64'(cp0_rst_inv_busy), 64'd0);
      $display("walk %s done_cycle=%0d last_grant=%0d", tag, done_cyc, last_grant);
   endtask

   initial begin
      cpurst_b              = 1'b0;
      ifu_cp0_rst_inv_req   = 1'b0;
      ifu_cp0_rst_mrvbr_req = 1'b0;
      pad_cpu_rvba          = '0;
      icache_cp0_inv_grant  = 1'b0;
`ifdef CT_CP0_RST_BHT_INV_EN
      bht_cp0_inv_done      = 1'b0;
`endif
      repeat (3) tick();
      check_idle("reset", '0);
      check("reset_idx", 64'(cp0_icache_inv_index), 64'd0);
      cpurst_b = 1'b1;
      repeat (2) tick();
      check_idle("post_reset", '0);

      // Full walk with grant tied high and a vector-base reload.
      pad_cpu_rvba = 40'h00_8000_0001;
      start(1'b1);
      check("t1_rvbr", 64'(cp0_ifu_rvbr), 64'h00_8000_0000);
      walk("t1", 1'b0, -1, -1, 257 + BHT_EXTRA);
      repeat (3) tick();
      check("t1_done_held", 64'(cp0_ifu_rst_inv_done), 64'd1);

      // Grant toggling: every index must wait for its grant.
      start(1'b0);
      check("t2_done_drop", 64'(cp0_ifu_rst_inv_done), 64'd0);
      walk("t2", 1'b1, -1, -1, 512 + BHT_EXTRA);

      // Micro-reset without reload keeps rvbr despite a new pad value.
      pad_cpu_rvba = 40'h00_0000_1000;
      start(1'b0);
      check("t3_done_drop", 64'(cp0_ifu_rst_inv_done), 64'd0);
      walk("t3", 1'b0, -1, -1, 257 + BHT_EXTRA);
      check("t3_rvbr", 64'(cp0_ifu_rvbr), 64'h00_8000_0000);

      // Mid-walk request at index 100 must be ignored.
      start(1'b0);
      walk("t4", 1'b0, 100, -1, 257 + BHT_EXTRA);

      // Asynchronous reset at index 50, then stay idle until a new request.
      start(1'b0);
      walk("t5", 1'b0, -1, 50, 0);
      repeat (2) tick();
      cpurst_b = 1'b1;
      repeat (4) tick();
      check_idle("t5_idle", '0);

      // Fresh walk after reset with reload of the changed pad value.
      start(1'b1);
      check("t6_rvbr", 64'(cp0_ifu_rvbr), 64'h00_0000_1000);
      walk("t6", 1'b0, -1, -1, 257 + BHT_EXTRA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
